// File: rtl/led_status_encoder.sv
// Purpose: picks one board status code by fixed priority and blinks it on the LED
//          as N pulses plus a long gap, or a slow heartbeat when everything is healthy.
// Latency: LED/code registered; a status change reaches the latched code within 2 cycles
//          from IDLE or from an aborted heartbeat.
// Backpressure: none; free-running source for the LED pin.
// Ports:
//   clk_input      - single clock for the block
//   rst_n          - synchronous active-low reset
//   ddr_calib_done - level, DDR3 calibration complete
//   sd_init_done   - level, SD card initialised
//   sd_err         - SD write/CRC error, captured as sticky
//   frame_pulse    - one-cycle pulse per CMOS frame
//   LED            - LED drive, active-high
//   code           - status code currently being displayed
module led_status_encoder #(
  parameter int unsigned TICK_DIV      = 2500000,
  parameter int unsigned ON_TICKS      = 10,
  parameter int unsigned OFF_TICKS     = 10,
  parameter int unsigned GAP_TICKS     = 50,
  parameter int unsigned HEART_TICKS   = 25,
  parameter int unsigned FRAME_TIMEOUT = 50
) (
  input  logic       clk_input,
  input  logic       rst_n,
  input  logic       ddr_calib_done,
  input  logic       sd_init_done,
  input  logic       sd_err,
  input  logic       frame_pulse,
  output logic       LED,
  output logic [2:0] code
);

  localparam int unsigned MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAX_B = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
  localparam int unsigned MAX_T = (MAX_B > 2 * HEART_TICKS) ? MAX_B : 2 * HEART_TICKS;
  localparam int TW = $clog2(MAX_T + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] HEART_LAST = TW'(2 * HEART_TICKS - 1);
  localparam logic [TW-1:0] HEART_HALF = TW'(HEART_TICKS);
  localparam logic [AW-1:0] AGE_MAX    = AW'(FRAME_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_GAP, S_HEART} state_t;

  state_t        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    pulses_q, pulses_d;
  logic          led_q, led_d;
  logic          err_q, err_d;
  logic [PW-1:0] fpre_q, fpre_d;
  logic [PW-1:0] spre_q, spre_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [AW-1:0] age_q, age_d;

  logic       f_tick;
  logic       seq_tick;
  logic       err_rise;
  logic [2:0] next_code;

  // Frame-staleness timer on its own free-running prescaler; a frame pulse
  // beats a simultaneous tick.
  always_comb begin
    f_tick = (fpre_q == PRE_LAST);
    fpre_d = f_tick ? '0 : fpre_q + PW'(1);
    age_d  = age_q;
    if (frame_pulse) begin
      age_d = '0;
    end else if (f_tick && (age_q != AGE_MAX)) begin
      age_d = age_q + AW'(1);
    end
  end

  // Error rise is taken straight from the input so the abort lands on the same
  // edge the sticky bit sets; the following IDLE then already sees code 4.
  assign err_d    = err_q | sd_err;
  assign err_rise = sd_err & ~err_q;

  always_comb begin
    if (err_q) begin
      next_code = 3'd4;
    end else if (!ddr_calib_done) begin
      next_code = 3'd1;
    end else if (!sd_init_done) begin
      next_code = 3'd2;
    end else if (age_q == AGE_MAX) begin
      next_code = 3'd3;
    end else begin
      next_code = 3'd0;
    end
  end

  assign seq_tick = (spre_q == PRE_LAST);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    pulses_d = pulses_q;
    unique case (state_q)
      S_IDLE: begin
        code_d   = next_code;
        pulses_d = 3'd0;
        state_d  = (next_code == 3'd0) ? S_HEART : S_ON;
      end
      S_ON: begin
        if (seq_tick && (tcnt_q == ON_LAST)) begin
          state_d  = S_OFF;
          pulses_d = pulses_q + 3'd1;
        end
      end
      S_OFF: begin
        if (seq_tick && (tcnt_q == OFF_LAST)) begin
          state_d = (pulses_q == code_q) ? S_GAP : S_ON;
        end
      end
      S_GAP: begin
        if (seq_tick && (tcnt_q == GAP_LAST)) begin
          state_d = S_IDLE;
        end
      end
      S_HEART: begin
        // Any fault pre-empts the heartbeat immediately.
        if (next_code != 3'd0) begin
          state_d = S_IDLE;
        end else if (seq_tick && (tcnt_q == HEART_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_rise) begin
      state_d  = S_IDLE;
      code_d   = code_q;
      pulses_d = pulses_q;
    end
  end

  // Sequence timing restarts on every state change so each state lasts an
  // exact whole number of ticks.
  always_comb begin
    if (state_d != state_q) begin
      spre_d = '0;
      tcnt_d = '0;
    end else begin
      spre_d = seq_tick ? '0 : spre_q + PW'(1);
      tcnt_d = seq_tick ? tcnt_q + TW'(1) : tcnt_q;
    end
  end

  // LED decoded from next state so the registered output lines up with the state.
  always_comb begin
    led_d = 1'b0;
    unique case (state_d)
      S_ON:    led_d = 1'b1;
      S_HEART: led_d = (tcnt_d < HEART_HALF);
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_input) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      code_q   <= 3'd0;
      pulses_q <= 3'd0;
      led_q    <= 1'b0;
      err_q    <= 1'b0;
      fpre_q   <= '0;
      spre_q   <= '0;
      tcnt_q   <= '0;
      age_q    <= AGE_MAX;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      pulses_q <= pulses_d;
      led_q    <= led_d;
      err_q    <= err_d;
      fpre_q   <= fpre_d;
      spre_q   <= spre_d;
      tcnt_q   <= tcnt_d;
      age_q    <= age_d;
    end
  end

  assign LED  = led_q;
  assign code = code_q;

endmodule

// File: doc/led_status_encoder.md
# led_status_encoder

Status blink-code generator feeding the board status LED. It samples system health signals, picks one status code by fixed priority, and emits that code as a blink sequence on `LED`: N pulses followed by a long gap, or a slow heartbeat when all is well. It sits directly upstream of the LED pin and replaces the free-running blinker as the LED source in the top level.

## Interface
- `TICK_DIV`, default 2500000: clock cycles per base tick; 20 ms at 125 MHz.
- `ON_TICKS`, default 10: ticks LED is high per code pulse.
- `OFF_TICKS`, default 10: ticks LED is low between code pulses.
- `GAP_TICKS`, default 50: ticks LED is low after the last pulse of a sequence.
- `HEART_TICKS`, default 25: ticks per heartbeat half-period.
- `FRAME_TIMEOUT`, default 50: ticks without `frame_pulse` before the frame stream counts as stale.
- `clk_input` in 1: single clock for the whole block.
- `rst_n` in 1: reset, synchronous and active-low.
- `ddr_calib_done` in 1: level; DDR3 calibration complete.
- `sd_init_done` in 1: level; SDHC card initialised.
- `sd_err` in 1: SD write or CRC error; captured as sticky.
- `frame_pulse` in 1: one-cycle pulse per CMOS frame.
- `LED` out 1: LED drive, active-high.
- `code` out 3: status code currently being displayed, as latched.

## Operation
- **Sticky error**: `err_sticky` sets on any cycle with `sd_err=1`. Only reset clears it.
- **Frame timer**: runs on a free-running prescaler with period `TICK_DIV`.
  - Counter `frame_age` increments on each free tick and saturates at `FRAME_TIMEOUT`.
  - `frame_pulse` clears `frame_age` to 0. If a pulse and a tick land on the same cycle, the pulse wins.
  - Reset value of `frame_age` is `FRAME_TIMEOUT`, so the stream reads as stale after reset.
- **Status code** (`next_code`), first true condition wins:
  - `err_sticky` → 4
  - `!ddr_calib_done` → 1
  - `!sd_init_done` → 2
  - `frame_age==FRAME_TIMEOUT` → 3
  - otherwise → 0
- **Sequence prescaler**:
  - Separate from the frame-timer prescaler.
  - Cleared on every state transition.
  - Issues `seq_tick` when it reaches `TICK_DIV-1`.
  - Tick counter `tcnt` is also cleared on every state transition.
- **FSM states**: IDLE, ON, OFF, GAP, HEART.
  - IDLE: `LED=0`. Next cycle: latch `code<=next_code` and `pulses<=0`. If `next_code==0` go to HEART, else go to ON.
  - ON: `LED=1`. On the `seq_tick` where `tcnt==ON_TICKS-1`, go to OFF and increment `pulses`.
  - OFF: `LED=0`. On the `seq_tick` where `tcnt==OFF_TICKS-1`: if `pulses==code` go to GAP, else go to ON.
  - GAP: `LED=0`. On the `seq_tick` where `tcnt==GAP_TICKS-1`, go to IDLE.
  - HEART: `LED=1` for the first `HEART_TICKS` ticks, then `LED=0` for `HEART_TICKS` ticks, then go to IDLE.
  - HEART aborts to IDLE on the first cycle where `next_code!=0`, so faults show without waiting.
- Once ON is entered, `code` is held until the sequence finishes; status changes mid-sequence do not truncate it. Exception: `err_sticky` rising aborts any state to IDLE on the next cycle.
- **Widths**: `tcnt` is wide enough for max(ON, OFF, GAP, 2×HEART) ticks; the prescaler is ceil(log2(`TICK_DIV`)) bits. All counters are unsigned.
- **Reset values** (`rst_n=0` at a clock edge, including mid-sequence): state IDLE, `LED=0`, `code=0`, `err_sticky=0`, `pulses=0`, both prescalers and `tcnt` = 0, `frame_age=FRAME_TIMEOUT`.

## Timing
- `LED` and `code` are registered. Status inputs to the latched `code` take at most 2 cycles when in IDLE or when aborting HEART.
- Each state lasts exactly (ticks × `TICK_DIV`) cycles, with IDLE lasting 1 cycle.
- Period of code N≥1 = N×(ON_TICKS+OFF_TICKS)×TICK_DIV + GAP_TICKS×TICK_DIV + 1 cycles.
- Heartbeat period = 2×HEART_TICKS×TICK_DIV + 1 cycles.
- All inputs are synchronous to `clk_input`; any synchronisers live upstream.

## Test plan
All scenarios use `TICK_DIV=4`, `ON=2`, `OFF=2`, `GAP=5`, `HEART=3`, `FRAME_TIMEOUT=8`.
- **Reset**: hold `rst_n=0` for 3 cycles with `ddr_calib_done=0` → `LED=0`, `code=0` during reset. After release, `code=1` and `LED` is high 8 cycles, low 8, low 20; period 37 cycles, repeating.
- **Code 2/3 and heartbeat**: set `ddr_calib_done=1`, `sd_init_done=0` → `code=2`, 2 pulses, period 53. Then `sd_init_done=1` with no frames → `code=3`, period 69. Then pulse `frame_pulse` every 20 cycles → `code=0`, `LED` high 12 / low 12, period 25.
- **Frame stale**: in heartbeat, stop `frame_pulse` → after 32 cycles `frame_age` saturates, heartbeat aborts, `code=3` within 2 cycles.
- **Sticky error**: one-cycle `sd_err` mid-ON of code 1 → next cycle state IDLE, then `code=4` with 4 pulses, period 85. Persists after `sd_err` drops until `rst_n=0`.
- **Latch hold**: in code 2 during the first ON, set `sd_init_done=1` → both pulses still complete, then the new code is latched in IDLE.
- **Reset mid-GAP**: assert `rst_n=0` for 1 cycle → all registers return to their reset values on that edge and the sequence restarts from IDLE.
